// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-master APB arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2
  } arb_state_e;

  localparam int NUM_MASTERS = 2;

  // Width of the ACCESS-cycle watchdog counter for a given timeout.
  function automatic int tcnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the master that was not served last wins.
module rr_arb2
  import apb_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic                   i_last,
  output logic                   o_gnt_idx,
  output logic                   o_gnt_valid
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    o_gnt_valid = |i_req;
    o_gnt_idx   = 1'b0;
    case (i_req)
      2'b01:   o_gnt_idx = 1'b0;
      2'b10:   o_gnt_idx = 1'b1;
      2'b11:   o_gnt_idx = ~i_last;
      default: o_gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/apb_arbiter_2m.sv
// Two-master round-robin APB arbiter; one downstream transfer at a time, losers stalled via pready.
// Optional per-transfer watchdog: define APB_ARB_TIMEOUT_EN.
module apb_arbiter_2m
  import apb_arb_pkg::*;
#(
  parameter int APB_AW         = 32,
  parameter int APB_DW         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  pclk,
  input  logic                  prst,

  input  logic                  i_s0_psel,
  input  logic [APB_AW-1:0]     i_s0_paddr,
  input  logic                  i_s0_pwrite,
  input  logic [APB_DW-1:0]     i_s0_pwdata,
  input  logic [APB_DW/8-1:0]   i_s0_pstrb,
  output logic                  o_s0_pready,
  output logic [APB_DW-1:0]     o_s0_prdata,
  output logic                  o_s0_pslverr,

  input  logic                  i_s1_psel,
  input  logic [APB_AW-1:0]     i_s1_paddr,
  input  logic                  i_s1_pwrite,
  input  logic [APB_DW-1:0]     i_s1_pwdata,
  input  logic [APB_DW/8-1:0]   i_s1_pstrb,
  output logic                  o_s1_pready,
  output logic [APB_DW-1:0]     o_s1_prdata,
  output logic                  o_s1_pslverr,

  output logic                  o_m_psel,
  output logic                  o_m_penable,
  output logic [APB_AW-1:0]     o_m_paddr,
  output logic                  o_m_pwrite,
  output logic [APB_DW-1:0]     o_m_pwdata,
  output logic [APB_DW/8-1:0]   o_m_pstrb,
  input  logic                  i_m_pready,
  input  logic [APB_DW-1:0]     i_m_prdata,
  input  logic                  i_m_pslverr,

  output logic                  o_timeout_seen
);

  localparam int SW = APB_DW / 8;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_arbiter_2m: TIMEOUT_CYCLES must be in 1..65535");
  end

  arb_state_e         r_state;
  logic               r_grant;
  logic               r_last;
  logic [APB_AW-1:0]  r_paddr;
  logic               r_pwrite;
  logic [APB_DW-1:0]  r_pwdata;
  logic [SW-1:0]      r_pstrb;

  logic [NUM_MASTERS-1:0] w_req;
  logic                   w_gnt_idx;
  logic                   w_gnt_valid;
  logic                   w_timeout;
  logic                   w_done;
  logic [APB_AW-1:0]      w_sel_paddr;
  logic                   w_sel_pwrite;
  logic [APB_DW-1:0]      w_sel_pwdata;
  logic [SW-1:0]          w_sel_pstrb;

  assign w_req = {i_s1_psel, i_s0_psel};

  rr_arb2 u_rr_arb2 (
    .i_req       (w_req),
    .i_last      (r_last),
    .o_gnt_idx   (w_gnt_idx),
    .o_gnt_valid (w_gnt_valid)
  );

  assign w_sel_paddr  = w_gnt_idx ? i_s1_paddr  : i_s0_paddr;
  assign w_sel_pwrite = w_gnt_idx ? i_s1_pwrite : i_s0_pwrite;
  assign w_sel_pwdata = w_gnt_idx ? i_s1_pwdata : i_s0_pwdata;
  assign w_sel_pstrb  = w_gnt_idx ? i_s1_pstrb  : i_s0_pstrb;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int                TCNT_W    = tcnt_width(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  logic [TCNT_W-1:0] r_tcnt;
  logic              r_timeout_seen;

  // Abort only when the slave has not answered in the final allowed ACCESS cycle.
  assign w_timeout = (r_state == ARB_ACCESS) && (r_tcnt == TCNT_LAST) && !i_m_pready;

  always_ff @(posedge pclk) begin
    if (prst) begin
      r_tcnt         <= '0;
      r_timeout_seen <= 1'b0;
    end else begin
      r_tcnt <= (r_state == ARB_ACCESS) ? r_tcnt + 1'b1 : '0;
      if (w_timeout) r_timeout_seen <= 1'b1;
    end
  end

  assign o_timeout_seen = r_timeout_seen;
`else
  assign w_timeout      = 1'b0;
  assign o_timeout_seen = 1'b0;
`endif

  assign w_done = (r_state == ARB_ACCESS) && (i_m_pready || w_timeout);

  // NOTE: sequential state uses non-blocking assignments only; the capture
  // registers are reset too so the downstream bus reads all-zero out of reset.
  always_ff @(posedge pclk) begin
    if (prst) begin
      r_state  <= ARB_IDLE;
      r_grant  <= 1'b0;
      r_last   <= 1'b1;
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_gnt_valid) begin
            r_state  <= ARB_SETUP;
            r_grant  <= w_gnt_idx;
            r_paddr  <= w_sel_paddr;
            r_pwrite <= w_sel_pwrite;
            r_pwdata <= w_sel_pwdata;
            r_pstrb  <= w_sel_pstrb;
          end
        end
        ARB_SETUP: r_state <= ARB_ACCESS;
        ARB_ACCESS: begin
          if (w_done) begin
            r_state <= ARB_IDLE;
            r_last  <= r_grant;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign o_m_psel    = (r_state == ARB_SETUP) || (r_state == ARB_ACCESS);
  assign o_m_penable = (r_state == ARB_ACCESS);
  assign o_m_paddr   = r_paddr;
  assign o_m_pwrite  = r_pwrite;
  assign o_m_pwdata  = r_pwdata;
  assign o_m_pstrb   = r_pstrb;

  // Only the granted master in ACCESS sees the slave; a watchdog abort forces an error with zero data.
  always_comb begin
    o_s0_pready  = 1'b0;
    o_s0_prdata  = '0;
    o_s0_pslverr = 1'b0;
    o_s1_pready  = 1'b0;
    o_s1_prdata  = '0;
    o_s1_pslverr = 1'b0;
    if (r_state == ARB_ACCESS) begin
      if (r_grant) begin
        o_s1_pready  = i_m_pready | w_timeout;
        o_s1_prdata  = w_timeout ? '0 : i_m_prdata;
        o_s1_pslverr = i_m_pslverr | w_timeout;
      end else begin
        o_s0_pready  = i_m_pready | w_timeout;
        o_s0_prdata  = w_timeout ? '0 : i_m_prdata;
        o_s0_pslverr = i_m_pslverr | w_timeout;
      end
    end
  end

endmodule
